// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory between an instruction-fetch requester and
// a data requester. Data has fixed priority. A starvation counter forces a
// fetch grant after STARVE_LIMIT data grants made while a fetch was pending.
// Every access follows IDLE -> ACCESS -> WAIT x WAIT_STATES -> RESP -> IDLE.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_inst_req,
  input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
  output logic                    o_inst_ack,
  output logic [DATA_WIDTH-1:0]   o_inst_rdata,
  input  logic                    i_data_req,
  input  logic                    i_data_we,
  input  logic [DATA_WIDTH/8-1:0] i_data_be,
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_wdata,
  output logic                    o_data_ack,
  output logic [DATA_WIDTH-1:0]   o_data_rdata,
  output logic                    o_mem_cs,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_busy
);

  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD  = CNT_WIDTH'(WAIT_STATES);
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 grant_inst;
  logic                 grant_data;
  logic                 owner_inst;
  logic                 owner_data;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] starve_cnt;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and arbitration; requests only matter in IDLE
  always_comb begin
    state_next = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_inst_req || i_data_req) begin
          if (i_inst_req && (!i_data_req || (starve_cnt == STARVE_MAX))) begin
            grant_inst = 1'b1;
          end else begin
            grant_data = 1'b1;
          end
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == CNT_WIDTH'(1)) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and owner; read data is a gated pass-through
  always_comb begin
    o_mem_cs     = (state == ST_ACCESS);
    o_busy       = (state != ST_IDLE);
    o_inst_ack   = (state == ST_RESP) && owner_inst;
    o_data_ack   = (state == ST_RESP) && owner_data;
    o_inst_rdata = '0;
    o_data_rdata = '0;
    if ((state == ST_RESP) && owner_inst) begin
      o_inst_rdata = i_mem_rdata;
    end
    if ((state == ST_RESP) && owner_data) begin
      o_data_rdata = i_mem_rdata;
    end
  end

  // Owner, memory command registers, wait and starvation counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      owner_inst  <= 1'b0;
      owner_data  <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
    end else begin
      if (grant_inst) begin
        owner_inst  <= 1'b1;
        owner_data  <= 1'b0;
        o_mem_we    <= 1'b0;
        o_mem_be    <= '1;
        o_mem_addr  <= i_inst_addr;
        o_mem_wdata <= '0;
      end else if (grant_data) begin
        owner_inst  <= 1'b0;
        owner_data  <= 1'b1;
        o_mem_we    <= i_data_we;
        o_mem_be    <= i_data_be;
        o_mem_addr  <= i_data_addr;
        o_mem_wdata <= i_data_wdata;
      end

      if (grant_inst) begin
        starve_cnt <= '0;
      end else if (grant_data && i_inst_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_WIDTH'(1);
      end

      if (state == ST_ACCESS) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - CNT_WIDTH'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // The owner must keep its request high until its ack cycle
  always @(posedge i_clock) begin
    if (!i_reset && (state != ST_IDLE)) begin
      assert (owner_inst ? i_inst_req : i_data_req)
        else $error("mem_bus_arbiter: owner dropped request before ack");
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. Two instances (WAIT_STATES=1 and 0)
// share the requester inputs; the one not under test is held in reset.
module tb_mem_bus_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int          LIM1 = 4;
  localparam int          LIM0 = 2;

  typedef struct {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            is_inst;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            chk;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          sel_ws0 = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [BW-1:0] data_be = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;

  logic          rst_1, rst_0;
  logic          iack_1, dack_1, cs_1, we_1, busy_1;
  logic          iack_0, dack_0, cs_0, we_0, busy_0;
  logic [DW-1:0] irdata_1, drdata_1, wdata_1, mrdata_1;
  logic [DW-1:0] irdata_0, drdata_0, wdata_0, mrdata_0;
  logic [AW-1:0] maddr_1, maddr_0;
  logic [BW-1:0] be_1, be_0;

  assign rst_1 = rst | sel_ws0;
  assign rst_0 = rst | ~sel_ws0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(1), .STARVE_LIMIT(LIM1)) u_ws1 (
    .i_clock(clk), .i_reset(rst_1),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr), .o_inst_ack(iack_1), .o_inst_rdata(irdata_1),
    .i_data_req(data_req), .i_data_we(data_we), .i_data_be(data_be), .i_data_addr(data_addr),
    .i_data_wdata(data_wdata), .o_data_ack(dack_1), .o_data_rdata(drdata_1),
    .o_mem_cs(cs_1), .o_mem_we(we_1), .o_mem_be(be_1), .o_mem_addr(maddr_1),
    .o_mem_wdata(wdata_1), .i_mem_rdata(mrdata_1), .o_busy(busy_1)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .STARVE_LIMIT(LIM0)) u_ws0 (
    .i_clock(clk), .i_reset(rst_0),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr), .o_inst_ack(iack_0), .o_inst_rdata(irdata_0),
    .i_data_req(data_req), .i_data_we(data_we), .i_data_be(data_be), .i_data_addr(data_addr),
    .i_data_wdata(data_wdata), .o_data_ack(dack_0), .o_data_rdata(drdata_0),
    .o_mem_cs(cs_0), .o_mem_we(we_0), .o_mem_be(be_0), .o_mem_addr(maddr_0),
    .o_mem_wdata(wdata_0), .i_mem_rdata(mrdata_0), .o_busy(busy_0)
  );

  // Memory contents: one fixed word plus an address-derived pattern
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h1357_2468;
  endfunction

  // Memory models: read data valid exactly WAIT_STATES+1 cycles after cs
  int            mcnt_1 = -1, mcnt_0 = -1;
  logic [AW-1:0] mlat_1 = '0, mlat_0 = '0;
  logic          mwe_1 = 1'b0, mwe_0 = 1'b0;

  always @(posedge clk) begin
    if (cs_1) begin mcnt_1 <= 1; mlat_1 <= maddr_1; mwe_1 <= we_1; end
    else if (mcnt_1 > 0) mcnt_1 <= mcnt_1 - 1;
    else mcnt_1 <= -1;
    if (cs_0) begin mcnt_0 <= 0; mlat_0 <= maddr_0; mwe_0 <= we_0; end
    else mcnt_0 <= -1;
  end

  assign mrdata_1 = (mcnt_1 == 0 && !mwe_1) ? mem_f(mlat_1) : 32'hBAD0_BAD0;
  assign mrdata_0 = (mcnt_0 == 0 && !mwe_0) ? mem_f(mlat_0) : 32'hBAD0_BAD0;

  // Outputs of the instance under test
  logic          iack, dack, cs, we, busy;
  logic [DW-1:0] irdata, drdata, wdata;
  logic [AW-1:0] maddr;
  logic [BW-1:0] be;
  assign iack   = sel_ws0 ? iack_0   : iack_1;
  assign dack   = sel_ws0 ? dack_0   : dack_1;
  assign cs     = sel_ws0 ? cs_0     : cs_1;
  assign we     = sel_ws0 ? we_0     : we_1;
  assign busy   = sel_ws0 ? busy_0   : busy_1;
  assign irdata = sel_ws0 ? irdata_0 : irdata_1;
  assign drdata = sel_ws0 ? drdata_0 : drdata_1;
  assign wdata  = sel_ws0 ? wdata_0  : wdata_1;
  assign maddr  = sel_ws0 ? maddr_0  : maddr_1;
  assign be     = sel_ws0 ? be_0     : be_1;

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  cmd_t cmd_q[$];
  rsp_t iq[$];
  rsp_t dq[$];
  int   cs_log[$];
  int   ack_log[$];
  bit   grant_log[$];
  cmd_t mon_cmd;
  rsp_t mon_rsp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: memory commands and responses against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (cs) begin
        cs_log.push_back(cyc);
        check_val("cmd_pending", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() != 0) begin
          mon_cmd = cmd_q.pop_front();
          check_val("mem_addr", 64'(maddr), 64'(mon_cmd.addr));
          check_val("mem_we", 64'(we), 64'(mon_cmd.we));
          check_val("mem_be", 64'(be), 64'(mon_cmd.be));
          if (!mon_cmd.is_inst) check_val("mem_wdata", 64'(wdata), 64'(mon_cmd.wdata));
        end
      end
      if (iack || dack) begin
        check_val("ack_onehot", 64'(iack & dack), 64'd0);
        ack_log.push_back(cyc);
        grant_log.push_back(iack);
      end
      if (iack) begin
        check_val("iack_pending", 64'(iq.size() != 0), 64'd1);
        if (iq.size() != 0) begin
          mon_rsp = iq.pop_front();
          if (mon_rsp.chk) check_val("inst_rdata", 64'(irdata), 64'(mon_rsp.rdata));
        end
      end else begin
        check_val("inst_rdata_idle", 64'(irdata), 64'd0);
      end
      if (dack) begin
        check_val("dack_pending", 64'(dq.size() != 0), 64'd1);
        if (dq.size() != 0) begin
          mon_rsp = dq.pop_front();
          if (mon_rsp.chk) check_val("data_rdata", 64'(drdata), 64'(mon_rsp.rdata));
        end
      end else begin
        check_val("data_rdata_idle", 64'(drdata), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_cs"}, 64'(cs), 64'd0);
    check_val({tag, "_acks"}, 64'({iack, dack}), 64'd0);
    check_val({tag, "_rdata"}, 64'(irdata | drdata), 64'd0);
    check_val({tag, "_mem"}, 64'({we, be, maddr}), 64'd0);
    check_val({tag, "_wdata"}, 64'(wdata), 64'd0);
  endtask

  // One arbitration round starting in an IDLE cycle: predict, drive, time it
  task automatic grant_one(input bit ireq, input bit dreq, input bit ilate, inout int s);
    bit   win_i;
    cmd_t c;
    rsp_t r;
    int   t0, lat, ws, lim, cs_at;
    ws  = sel_ws0 ? 0 : 1;
    lim = sel_ws0 ? LIM0 : LIM1;
    inst_req = ireq & !ilate;
    data_req = dreq;
    win_i = inst_req && (!data_req || s == lim);
    if (win_i) s = 0;
    else if (inst_req && s < lim) s++;
    c.is_inst = win_i;
    c.we      = win_i ? 1'b0 : data_we;
    c.be      = win_i ? '1 : data_be;
    c.addr    = win_i ? inst_addr : data_addr;
    c.wdata   = data_wdata;
    cmd_q.push_back(c);
    r.chk   = !c.we;
    r.rdata = mem_f(c.addr);
    if (win_i) iq.push_back(r);
    else dq.push_back(r);
    t0  = cyc;
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_val("busy", 64'(busy), 64'(k > 0));
      if (iack || dack) begin
        lat = k;
        break;
      end
      tick();
      if (k == 0 && ilate) inst_req = 1'b1;
    end
    cs_at = (cs_log.size() != 0) ? cs_log[$] - t0 : -1;
    check_val("ack_latency", 64'(lat), 64'(ws + 2));
    check_val("cs_cycle", 64'(cs_at), 64'd1);
    tick();
    if (win_i) inst_addr = inst_addr + 32'd4;
    else data_addr = data_addr + 32'd4;
  endtask

  int s;
  int exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp6[6]  = '{0, 0, 0, 1, 0, 1};

  initial begin
    s = 0;
    // Reset state of the WAIT_STATES=1 instance
    tick();
    tick();
    check_quiet("reset_ws1");
    tick();
    rst = 1'b0;

    // Single fetch
    inst_addr = 32'h0000_0100;
    grant_one(1'b1, 1'b0, 1'b0, s);

    // Single data write; no fetch ack may appear
    data_we = 1'b1; data_be = 4'b0011; data_addr = 32'h0000_2004; data_wdata = 32'h0000_1234;
    grant_one(1'b0, 1'b1, 1'b0, s);

    // Both requests held: starvation rotation
    data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_4000; inst_addr = 32'h0000_3000;
    grant_log.delete();
    for (int i = 0; i < 10; i++) grant_one(1'b1, 1'b1, 1'b0, s);
    for (int i = 0; i < 10; i++)
      check_val("order_ws1", 64'((grant_log.size() > i) ? grant_log[i] : 1'bx), 64'(exp3[i]));
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // Reset during the WAIT state of a fetch
    inst_req = 1'b1; inst_addr = 32'h0000_0500;
    cmd_q.push_back('{we: 1'b0, be: '1, addr: 32'h0000_0500, wdata: '0, is_inst: 1'b1});
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_val("wait_no_ack", 64'({iack, dack}), 64'd0);
    tick();
    check_quiet("rst_in_wait");
    tick();
    rst = 1'b0;
    s = 0;
    grant_one(1'b1, 1'b0, 1'b0, s);
    inst_req = 1'b0;
    tick();

    // Switch to the WAIT_STATES=0 instance
    rst = 1'b1;
    sel_ws0 = 1'b1;
    tick();
    tick();
    check_quiet("reset_ws0");
    tick();
    rst = 1'b0;
    s = 0;

    // Back-to-back data reads
    data_we = 1'b0; data_addr = 32'h0000_6000;
    cs_log.delete(); ack_log.delete();
    for (int i = 0; i < 3; i++) grant_one(1'b0, 1'b1, 1'b0, s);
    for (int i = 0; i < 2; i++) begin
      check_val("b2b_ack_gap", 64'((ack_log.size() == 3) ? ack_log[i+1] - ack_log[i] : -1), 64'd3);
      check_val("b2b_cs_after_ack", 64'((cs_log.size() == 3) ? cs_log[i+1] - ack_log[i] : -1), 64'd2);
    end

    // Late fetch against data traffic, then data dropping out
    grant_log.delete();
    grant_one(1'b1, 1'b1, 1'b1, s);
    for (int i = 0; i < 4; i++) grant_one(1'b1, 1'b1, 1'b0, s);
    grant_one(1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < 6; i++)
      check_val("order_ws0", 64'((grant_log.size() > i) ? grant_log[i] : 1'bx), 64'(exp6[i]));
    inst_req = 1'b0; data_req = 1'b0;
    tick();
    tick();
    check_val("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check_val("resp_q_empty", 64'(iq.size() + dq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
